bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 13 +
 rtl/bit_serializer.sv | 107 ++++++++++
 tb/tb_bit_serializer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and default parameters for the bit serializer.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam bit DEF_IDLE_BIT = 1'b0;
    localparam int DEF_LEN_W    = 4;

endpackage

// File: rtl/bit_serializer.sv
// MSB-first word serializer with a one-word hold register so that
// consecutive words stream out with no gap cycles.
//
// state | meaning
// IDLE  | no bits pending, X parked at IDLE_BIT
// SHIFT | a word is being sent, one bit per cycle
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter bit IDLE_BIT = DEF_IDLE_BIT,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             X,
    output logic             x_valid,
    output logic             word_done
);

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] cnt;
    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic [LEN_W-1:0] hold_len;

    logic             accept;
    logic             last_bit;
    logic             do_load;
    logic             do_shift;
    logic             to_hold;
    logic [WIDTH-1:0] src_data;
    logic [LEN_W-1:0] src_len;
    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;

    assign in_ready = !hold_valid && !flush;
    assign accept   = in_valid && in_ready;
    assign last_bit = (state == SHIFT) && (cnt == '0);
    assign do_load  = ((state == IDLE) && accept) || (last_bit && (hold_valid || accept));
    assign do_shift = (state == SHIFT) && !last_bit;
    assign to_hold  = do_shift && accept;

    // The hold word always wins the load slot; it can only be full in SHIFT.
    always_comb begin
        src_data = hold_valid ? hold_data : in_data;
        src_len  = hold_valid ? hold_len  : in_len;
        eff_len  = ((src_len == '0) || (src_len > FULL_LEN)) ? FULL_LEN : src_len;
        aligned  = src_data << (FULL_LEN - eff_len);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_len   <= '0;
            X          <= IDLE_BIT;
            x_valid    <= 1'b0;
            word_done  <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            cnt        <= '0;
            hold_valid <= 1'b0;
            X          <= IDLE_BIT;
            x_valid    <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            // cnt counts bits still to follow the one currently on X
            if (do_load) begin
                state      <= SHIFT;
                X          <= aligned[WIDTH-1];
                shreg      <= aligned << 1;
                cnt        <= eff_len - LEN_W'(1);
                x_valid    <= 1'b1;
                word_done  <= (eff_len == LEN_W'(1));
                hold_valid <= 1'b0;
            end else if (do_shift) begin
                X         <= shreg[WIDTH-1];
                shreg     <= shreg << 1;
                cnt       <= cnt - LEN_W'(1);
                word_done <= (cnt == LEN_W'(1));
            end else begin
                state     <= IDLE;
                X         <= IDLE_BIT;
                x_valid   <= 1'b0;
                word_done <= 1'b0;
            end
            if (to_hold) begin
                hold_valid <= 1'b1;
                hold_data  <= in_data;
                hold_len   <= in_len;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: a bit-queue reference model checked every cycle,
// directed streams with literal expectations, then randomized traffic.
module tb_bit_serializer;

    localparam int WIDTH    = 8;
    localparam int LEN_W    = 4;
    localparam bit IDLE_BIT = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             X;
    logic             x_valid;
    logic             word_done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit b;
        bit last;
    } ent_t;

    ent_t q[$];
    bit   seen_b[$];
    bit   seen_d[$];

    bit_serializer #(
        .WIDTH   (WIDTH),
        .IDLE_BIT(IDLE_BIT),
        .LEN_W   (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .in_data  (in_data),
        .in_len   (in_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .X        (X),
        .x_valid  (x_valid),
        .word_done(word_done)
    );

    always #5 clk = ~clk;

    function automatic int words_pending();
        int n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    // Reference: a queue of the bits still to appear on X, front = bit on X now.
    // The hold register is full exactly when two words are pending.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            int  e;
            bit  rdy;
            rdy = !flush && (words_pending() < 2);
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0) void'(q.pop_front());
                if (in_valid && rdy) begin
                    e = ((in_len == 0) || (int'(in_len) > WIDTH)) ? WIDTH : int'(in_len);
                    for (int i = e - 1; i >= 0; i--) q.push_back('{in_data[i], (i == 0)});
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev, ex, ed, er;
        ev = (q.size() > 0);
        ex = ev ? q[0].b : IDLE_BIT;
        ed = ev && q[0].last;
        er = !flush && (words_pending() < 2);
        vectors++;
        if (x_valid !== ev || X !== ex || word_done !== ed || in_ready !== er) begin
            miscompares++;
            $display("FAIL cycle t=%0t got X=%b x_valid=%b word_done=%b in_ready=%b want X=%b x_valid=%b word_done=%b in_ready=%b",
                     $time, X, x_valid, word_done, in_ready, ex, ev, ed, er);
        end
        if (x_valid === 1'b1) begin
            seen_b.push_back(X);
            seen_d.push_back(word_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic check_stream(input string name, input logic [31:0] exp, input int n, input int words);
        logic [31:0] got = '0;
        int ndone = 0;
        bit ok;
        foreach (seen_b[i]) got = {got[30:0], seen_b[i]};
        foreach (seen_d[i]) if (seen_d[i]) ndone++;
        ok = (seen_b.size() == n) && (got == exp) && (ndone == words);
        if (ok && words > 0) ok = seen_d[n-1];
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s got bits=%0h count=%0d dones=%0d want bits=%0h count=%0d dones=%0d",
                     name, got, seen_b.size(), ndone, exp, n, words);
        end
    endtask

    task automatic drive_word(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
        bit acc = 1'b0;
        in_data  = d;
        in_len   = l;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout got in_ready=0 want acceptance of %0h", d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_len   = '0;
        #12;
        check("reset_x", 32'(X), 32'(IDLE_BIT));
        check("reset_x_valid", 32'(x_valid), 0);
        check("reset_word_done", 32'(word_done), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        tick();

        seen_b.delete(); seen_d.delete();
        drive_word(8'h0E, 4'd4);
        idle(8);
        check_stream("single_0e", 32'b1110, 4, 1);

        seen_b.delete(); seen_d.delete();
        drive_word(8'h0E, 4'd4);
        drive_word(8'h07, 4'd4);
        check("hold_full_ready", 32'(in_ready), 0);
        idle(10);
        check_stream("b2b_0e_07", 32'b11100111, 8, 2);

        seen_b.delete(); seen_d.delete();
        drive_word(8'hA5, 4'd0);
        idle(12);
        check_stream("len0_a5", 32'b10100101, 8, 1);

        seen_b.delete(); seen_d.delete();
        drive_word(8'h0E, 4'd4);
        drive_word(8'h07, 4'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_x_valid", 32'(x_valid), 0);
        idle(10);
        check_stream("flush_2nd_bit", 32'b11, 2, 0);

        drive_word(8'hA5, 4'd8);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_x_valid", 32'(x_valid), 0);
        check("async_rst_x", 32'(X), 32'(IDLE_BIT));
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        seen_b.delete(); seen_d.delete();
        drive_word(8'h0E, 4'd4);
        idle(8);
        check_stream("after_reset", 32'b1110, 4, 1);

        seen_b.delete(); seen_d.delete();
        drive_word(8'h0E, 4'd4);
        drive_word(8'h35, 4'd6);
        drive_word(8'h07, 4'd4);
        idle(16);
        check_stream("stable_valid_3w", 32'b11101101010111, 14, 3);

        seen_b.delete(); seen_d.delete();
        drive_word(8'h5A, 4'd12);
        idle(12);
        check_stream("len_over_width", 32'b01011010, 8, 1);

        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = WIDTH'($urandom);
            in_len   = LEN_W'($urandom_range(0, 15));
            flush    = ($urandom_range(0, 99) < 3);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
